seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 27 ++
 rtl/seg_slot_timer.sv | 79 +++++++
 rtl/seg_scan_mux.sv | 108 ++++++++++
 tb/tb_seg_scan_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and helpers for the 2-digit segment scanner
//
// Purpose: segment/anode encodings and the polarity helper used by the
// scan multiplexer and its slot timer.
// Ports: none (package).

package seg_scan_pkg;

    // 7-segment pattern for the digit '0' (a..f lit, g dark), bit0=a .. bit6=g
    localparam logic [6:0] SEG_ZERO   = 7'b0111111;

    // Which digit owns the current slot
    localparam logic       DIGIT_ONES = 1'b0;
    localparam logic       DIGIT_TENS = 1'b1;

    // Anode enables are active-low; an[0]=ones, an[1]=tens
    localparam logic [1:0] AN_OFF     = 2'b11;
    localparam logic [1:0] AN_ONES    = 2'b10;
    localparam logic [1:0] AN_TENS    = 2'b01;

    // Convert an active-high segment pattern to the bus polarity.
    function automatic logic [6:0] seg_pol(input logic [6:0] pattern,
                                           input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - slot counter, digit select and brightness on-window
//
// Purpose: counts clock cycles within a digit slot, alternates the digit at
// each slot wrap, samples brightness at every slot start and decides whether
// the current cycle falls in the lit window. All outputs are combinational
// views of the pre-edge state; the parent registers what it drives off-chip.
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous, active-high
//   bright_i[2:0]  requested brightness, sampled at slot start
//   lit_o          current cycle is inside the on-window of the slot
//   digit_o        digit owning the current slot (0=ones, 1=tens)
//   slot_start_o   current cycle is slot position 0
//   frame_start_o  current cycle is slot position 0 of the ones slot

module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYCLES  = 18,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] bright_i,
    output logic       lit_o,
    output logic       digit_o,
    output logic       slot_start_o,
    output logic       frame_start_o
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    // Cycles of on-time added per brightness level
    localparam int STEP  = (SLOT_CYCLES - BLANK_CYCLES) / 8;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic             digit_q, digit_d;
    logic [2:0]       bright_q, bright_d;
    logic [31:0]      on_len;
    logic [31:0]      cnt_ext;

    always_comb begin
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        digit_d    = digit_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            digit_d    = ~digit_q;
        end
        // Brightness only changes on slot boundaries so a slot never
        // gets a mixture of two on-lengths.
        bright_d = (slot_cnt_q == '0) ? bright_i : bright_q;
    end

    always_comb begin
        on_len  = (32'(bright_q) + 32'd1) * 32'(STEP);
        cnt_ext = 32'(slot_cnt_q);
        // The window never reaches past the slot end, so the leading
        // BLANK_CYCLES of the next slot always separate two lit digits.
        lit_o   = (cnt_ext >= 32'(BLANK_CYCLES)) &&
                  (cnt_ext <  32'(BLANK_CYCLES) + on_len);
    end

    assign digit_o       = digit_q;
    assign slot_start_o  = (slot_cnt_q == '0);
    assign frame_start_o = (slot_cnt_q == '0) && (digit_q == DIGIT_ONES);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_cnt_q <= '0;
            digit_q    <= DIGIT_ONES;
            bright_q   <= 3'd0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
            bright_q   <= bright_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 2-digit common-anode display scanner with PWM and blanking
//
// Purpose: time-multiplexes the tens/ones segment patterns onto one shared
// segment bus, with inter-digit blanking, 8-level brightness, optional
// leading-zero blanking and per-frame capture of the digit patterns.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   seg_tens     tens pattern, active-high, bit0=a .. bit6=g
//   seg_ones     ones pattern, same encoding
//   bright       brightness 0 (dimmest) .. 7 (full)
//   lz_en        1 = blank the tens digit when it shows '0'
//   seg_out      shared segment bus, polarity set by SEG_ACTIVE_LOW
//   an           anode enables, active-low; an[0]=ones, an[1]=tens
//   frame_start  one-cycle pulse at the start of each frame

module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYCLES    = 18,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    input  logic [2:0] bright,
    input  logic       lz_en,
    output logic [6:0] seg_out,
    output logic [1:0] an,
    output logic       frame_start
);

    localparam logic [6:0] SEG_OFF = seg_pol(7'h00, SEG_ACTIVE_LOW);

    logic       lit;
    logic       digit;
    logic       slot_start;
    logic       frame_start_now;

    logic [6:0] shadow_tens_q, shadow_tens_d;
    logic [6:0] shadow_ones_q, shadow_ones_d;
    logic       lz_q, lz_d;
    logic [6:0] seg_out_q, seg_out_d;
    logic [1:0] an_q, an_d;
    logic       frame_start_q, frame_start_d;
    logic       tens_blanked;

    seg_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .bright_i      (bright),
        .lit_o         (lit),
        .digit_o       (digit),
        .slot_start_o  (slot_start),
        .frame_start_o (frame_start_now)
    );

    always_comb begin
        // Patterns are only taken at frame start so a count change in the
        // middle of a frame can never show one new and one old digit.
        shadow_tens_d = frame_start_now ? seg_tens : shadow_tens_q;
        shadow_ones_d = frame_start_now ? seg_ones : shadow_ones_q;
        lz_d          = slot_start      ? lz_en    : lz_q;
        frame_start_d = frame_start_now;

        tens_blanked  = lz_q && (shadow_tens_q == SEG_ZERO);

        an_d      = AN_OFF;
        seg_out_d = SEG_OFF;
        if (lit) begin
            if (digit == DIGIT_ONES) begin
                an_d      = AN_ONES;
                seg_out_d = seg_pol(shadow_ones_q, SEG_ACTIVE_LOW);
            end else if (!tens_blanked) begin
                an_d      = AN_TENS;
                seg_out_d = seg_pol(shadow_tens_q, SEG_ACTIVE_LOW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_tens_q <= 7'h00;
            shadow_ones_q <= 7'h00;
            lz_q          <= 1'b0;
            seg_out_q     <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            shadow_tens_q <= shadow_tens_d;
            shadow_ones_q <= shadow_ones_d;
            lz_q          <= lz_d;
            seg_out_q     <= seg_out_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux

module tb_seg_scan_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_tens = 7'h00;
    logic [6:0] seg_ones = 7'h00;
    logic [2:0] bright = 3'd0;
    logic       lz_en = 1'b0;

    logic [6:0] seg_lo, seg_hi;
    logic [1:0] an_lo, an_hi;
    logic       fs_lo, fs_hi;

    int n_cmp = 0;
    int n_bad = 0;
    int e = -1;

    always #5 clk = ~clk;

    seg_scan_mux #(.SLOT_CYCLES(18), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .bright(bright), .lz_en(lz_en), .seg_out(seg_lo), .an(an_lo),
        .frame_start(fs_lo)
    );

    seg_scan_mux #(.SLOT_CYCLES(18), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .bright(bright), .lz_en(lz_en), .seg_out(seg_hi), .an(an_hi),
        .frame_start(fs_hi)
    );

    typedef struct {
        string      name;
        logic [6:0] tens;
        logic [6:0] ones;
        logic [2:0] br;
        logic       lz;
        int         edge_no;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fs;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int n);
        while (e < n) step();
    endtask

    // Hold reset for two edges; the next edge is E0.
    task automatic start(input logic [6:0] t, input logic [6:0] o,
                         input logic [2:0] b, input logic l);
        seg_tens = t;
        seg_ones = o;
        bright   = b;
        lz_en    = l;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        e     = -1;
    endtask

    // exp_seg is the active-low bus value; the active-high instance must
    // show its complement (pattern when lit, 7'h00 when dark).
    task automatic chk(input string name, input logic [1:0] xan,
                       input logic [6:0] xseg, input logic xfs);
        n_cmp++;
        if (an_lo !== xan || seg_lo !== xseg || fs_lo !== xfs ||
            an_hi !== xan || seg_hi !== ~xseg || fs_hi !== xfs) begin
            n_bad++;
            $display("FAIL %s @E%0d: an=%b/%b seg=%b/%b fs=%b/%b, required an=%b seg=%b/%b fs=%b",
                     name, e, an_lo, an_hi, seg_lo, seg_hi, fs_lo, fs_hi,
                     xan, xseg, ~xseg, xfs);
        end
    endtask

    localparam logic [6:0] T1  = 7'b1011011;
    localparam logic [6:0] O1  = 7'b0000110;
    localparam logic [6:0] O2  = 7'b1101101;
    localparam logic [6:0] Z   = 7'b0111111;
    localparam logic [6:0] OFF = 7'h7F;

    initial begin
        // Table: each record restarts from reset with its inputs.
        vecs.push_back('{"s1_e0",  T1, O1, 3'd7, 1'b0,  0, 2'b11, OFF,       1'b1});
        vecs.push_back('{"s1_e1",  T1, O1, 3'd7, 1'b0,  1, 2'b11, OFF,       1'b0});
        vecs.push_back('{"s1_e2",  T1, O1, 3'd7, 1'b0,  2, 2'b10, 7'b1111001, 1'b0});
        vecs.push_back('{"s1_e17", T1, O1, 3'd7, 1'b0, 17, 2'b10, 7'b1111001, 1'b0});
        vecs.push_back('{"s1_e18", T1, O1, 3'd7, 1'b0, 18, 2'b11, OFF,       1'b0});
        vecs.push_back('{"s1_e19", T1, O1, 3'd7, 1'b0, 19, 2'b11, OFF,       1'b0});
        vecs.push_back('{"s1_e20", T1, O1, 3'd7, 1'b0, 20, 2'b01, 7'b0100100, 1'b0});
        vecs.push_back('{"s1_e35", T1, O1, 3'd7, 1'b0, 35, 2'b01, 7'b0100100, 1'b0});
        vecs.push_back('{"s1_e36", T1, O1, 3'd7, 1'b0, 36, 2'b11, OFF,       1'b1});
        vecs.push_back('{"s1_e72", T1, O1, 3'd7, 1'b0, 72, 2'b11, OFF,       1'b1});
        vecs.push_back('{"b0_e2",  T1, O1, 3'd0, 1'b0,  2, 2'b10, 7'b1111001, 1'b0});
        vecs.push_back('{"b0_e3",  T1, O1, 3'd0, 1'b0,  3, 2'b10, 7'b1111001, 1'b0});
        vecs.push_back('{"b0_e4",  T1, O1, 3'd0, 1'b0,  4, 2'b11, OFF,       1'b0});
        vecs.push_back('{"b0_e17", T1, O1, 3'd0, 1'b0, 17, 2'b11, OFF,       1'b0});
        vecs.push_back('{"b0_e21", T1, O1, 3'd0, 1'b0, 21, 2'b01, 7'b0100100, 1'b0});
        vecs.push_back('{"b0_e22", T1, O1, 3'd0, 1'b0, 22, 2'b11, OFF,       1'b0});
        vecs.push_back('{"b0_e36", T1, O1, 3'd0, 1'b0, 36, 2'b11, OFF,       1'b1});
        vecs.push_back('{"b3_e9",  T1, O1, 3'd3, 1'b0,  9, 2'b10, 7'b1111001, 1'b0});
        vecs.push_back('{"b3_e10", T1, O1, 3'd3, 1'b0, 10, 2'b11, OFF,       1'b0});
        vecs.push_back('{"lz_ones",Z,  O2, 3'd7, 1'b1,  2, 2'b10, 7'b0010010, 1'b0});
        vecs.push_back('{"lz_tens",Z,  O2, 3'd7, 1'b1, 20, 2'b11, OFF,       1'b0});
        vecs.push_back('{"lz_nz",  T1, O2, 3'd7, 1'b1, 20, 2'b01, 7'b0100100, 1'b0});
        vecs.push_back('{"nolz_z", Z,  O2, 3'd7, 1'b0, 20, 2'b01, 7'b1000000, 1'b0});

        // Reset state, checked while reset is still high.
        reset = 1'b1;
        step();
        step();
        chk("reset_state", 2'b11, OFF, 1'b0);

        foreach (vecs[i]) begin
            start(vecs[i].tens, vecs[i].ones, vecs[i].br, vecs[i].lz);
            run_to(vecs[i].edge_no);
            chk(vecs[i].name, vecs[i].exp_an, vecs[i].exp_seg, vecs[i].exp_fs);
        end

        // Three full frames of scenario 1, cycle by cycle.
        start(T1, O1, 3'd7, 1'b0);
        for (int n = 0; n < 108; n++) begin
            int k, s;
            logic [1:0] xan;
            logic [6:0] xseg;
            step();
            k = e % 36;
            s = k % 18;
            xan  = 2'b11;
            xseg = OFF;
            if (s >= 2) begin
                xan  = (k < 18) ? 2'b10 : 2'b01;
                xseg = (k < 18) ? 7'b1111001 : 7'b0100100;
            end
            chk("s1_frame", xan, xseg, k == 0);
        end

        // Leading zero with a mid-frame tens change.
        start(Z, O2, 3'd7, 1'b1);
        for (int n = 0; n < 36; n++) begin
            step();
            if (e == 10) seg_tens = O1;
            n_cmp++;
            if (an_lo === 2'b01 || an_hi === 2'b01) begin
                n_bad++;
                $display("FAIL lz_no_tens @E%0d: an=%b/%b, required not 01", e, an_lo, an_hi);
            end
        end
        run_to(38);
        chk("lz_ones_next", 2'b10, 7'b0010010, 1'b0);
        run_to(56);
        chk("lz_tens_next", 2'b01, 7'b1111001, 1'b0);

        // seg_ones changes mid ones-slot: old pattern held until next frame.
        start(T1, O1, 3'd7, 1'b0);
        run_to(10);
        seg_ones = O2;
        run_to(17);
        chk("ones_hold", 2'b10, 7'b1111001, 1'b0);
        run_to(37);
        chk("ones_gap", 2'b11, OFF, 1'b0);
        run_to(38);
        chk("ones_new", 2'b10, 7'b0010010, 1'b0);

        // One-cycle reset in the middle of the tens slot.
        start(T1, O1, 3'd7, 1'b0);
        run_to(24);
        reset = 1'b1;
        step();
        chk("mid_reset", 2'b11, OFF, 1'b0);
        reset = 1'b0;
        e = -1;
        run_to(0);
        chk("rst_e0", 2'b11, OFF, 1'b1);
        run_to(1);
        chk("rst_e1", 2'b11, OFF, 1'b0);
        run_to(2);
        chk("rst_e2", 2'b10, 7'b1111001, 1'b0);
        run_to(20);
        chk("rst_e20", 2'b01, 7'b0100100, 1'b0);
        run_to(36);
        chk("rst_e36", 2'b11, OFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Anti-ghosting: both anodes must never be enabled together.
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (an_lo === 2'b00 || an_hi === 2'b00) begin
                n_bad++;
                $display("FAIL both_anodes: an=%b/%b, required not 00", an_lo, an_hi);
            end
        end
    end

endmodule
